ones_mod3_sequencer: RTL and testbench
======================================

# ones_mod3_sequencer

Frame-level controller for the serial ones-divisible-by-3 detector datapath. It accepts parallel words over a valid/ready handshake and serializes each word LSB-first onto a bit stream. It keeps the mod-3 residue of the ones count across all words of a frame. When the word marked last has been fully shifted, it presents a single per-frame verdict, "total ones divisible by 3", plus the frame's word count, and holds it until the consumer takes it.

## Interface
- WIDTH, 8, bits per input word (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  word to serialize, shifted LSB first
- in_last  in  1  qualifies in_data as the final word of a frame
- x  out  1  serial bit stream (current bit)
- bit_valid  out  1  x carries a frame bit this cycle
- out_valid  out  1  frame verdict available
- out_ready  in  1  consumer takes the verdict
- out_div3  out  1  1 = frame ones count ≡ 0 mod 3
- out_words  out  8  words in the frame, saturating at 255

## Operation
- Only one clock; reset asynchronous and active-high. Reset values:
  - state=IDLE, residue=0, word count=0
  - x=0, bit_valid=0, out_valid=0, out_div3=0, out_words=0
  - in_ready=1 once reset deasserts
- States:
  - IDLE: in_ready=1, bit_valid=0.
    - On in_valid&in_ready: capture in_data into the shift register and capture in_last.
    - Load bit counter with WIDTH; increment word count (saturate at 255); go SHIFT.
  - SHIFT: in_ready=0.
    - Each cycle: x=shreg[0], bit_valid=1, shift right, decrement counter.
    - Residue update per bit: 1 → residue=(residue+1) mod 3; 0 → unchanged.
    - After the WIDTH-th bit: go DONE if the captured last=1, else IDLE.
    - The residue is carried across words within a frame.
  - DONE: in_ready=0, bit_valid=0, out_valid=1.
    - out_div3=(residue==0), including the WIDTH bit of the final word.
    - out_words = word count.
    - On out_ready: clear residue and word count, deassert out_valid, go IDLE.
- in_valid while in_ready=0 is ignored; no word is dropped if the source holds it.
- out_div3/out_words are stable while out_valid=1 and out_ready=0.
- A frame with zero ones reports out_div3=1 (residue starts at 0).
- Word count saturates at 255 and never wraps. The residue is unaffected by saturation.
- Reset mid-frame (any state) abandons the frame: no verdict is emitted, and the next frame starts from residue 0 and count 0.
- in_last on a word that is not accepted has no effect.

## Timing
- Word accepted at edge t:
  - bits 0..WIDTH-1 appear on x/bit_valid in cycles t+1..t+WIDTH
  - in_ready returns high at t+WIDTH+1 (non-last word)
- Last word accepted at t: out_valid=1 from cycle t+WIDTH+1.
- Verdict taken at edge u (out_valid&out_ready): out_valid=0 and in_ready=1 from cycle u+1.
- Throughput: one word per WIDTH+1 cycles.
- Frame overhead: one extra cycle plus the consumer wait.
- x, bit_valid, out_* are registered.
- in_ready is a decode of the state register (no combinational path from inputs).

## Test plan
- Reset: assert reset mid-cycle (asynchronous).
  - Required: out_valid=0, bit_valid=0, x=0, out_div3=0, out_words=0; in_ready=1 after release.
- WIDTH=8, single word 0x07 with in_last=1, accepted at t.
  - Required: x=1,1,1,0,0,0,0,0 in cycles t+1..t+8 with bit_valid=1.
  - Required: out_valid at t+9 with out_div3=1, out_words=1.
- Two-word frame, 0x01 then 0x01 with in_last=1.
  - Required: out_div3=0 (2 ones), out_words=2.
  - Then 0x03 + 0x01 (in_last=1) gives out_div3=1, out_words=2; residue cleared between frames.
- Frame of one word 0x00, in_last=1 → out_div3=1, out_words=1.
  - 256 words of 0x00 with the last flagged → out_words=255.
- Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid.
  - Required: out_valid/out_div3/out_words stable, in_ready=0, no word accepted.
  - out_ready=1 → out_valid drops next cycle, in_ready=1.
- Reset in SHIFT after 3 bits of 0xFF (last=1).
  - Required: no out_valid.
  - Next frame 0x07 (last=1) → out_div3=1, out_words=1.

Source files
------------

// File: rtl/ones_mod3_sequencer.sv
// ones_mod3_sequencer
//
// Frame-level controller for the serial ones-divisible-by-3 detector.
// The block accepts parallel words over a valid/ready handshake and shifts
// each word out LSB-first on a registered bit stream. It keeps the ones
// count of the frame modulo 3 across all words of the frame. When the word
// flagged as last has been fully shifted out, it presents one verdict for
// the frame and holds it until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   input word present
//   in_ready   block can accept a word (decoded from state only)
//   in_data    word to serialize, LSB first
//   in_last    marks in_data as the final word of its frame
//   x          serial bit stream (registered)
//   bit_valid  x carries a frame bit this cycle (registered)
//   out_valid  frame verdict available (registered)
//   out_ready  consumer takes the verdict
//   out_div3   1 when the frame ones count is a multiple of 3
//   out_words  words in the frame, saturating at 255

module ones_mod3_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             x,
    output logic             bit_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_div3,
    output logic [7:0]       out_words
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [1:0]       residue_q, residue_d;
    logic [7:0]       words_q, words_d;
    logic             x_q, x_d;
    logic             bit_valid_q, bit_valid_d;
    logic             out_valid_q, out_valid_d;
    logic             out_div3_q, out_div3_d;
    logic [7:0]       out_words_q, out_words_d;

    // Advance a mod-3 residue by one bit: a 1 steps 0->1->2->0.
    function automatic logic [1:0] bump(input logic [1:0] r, input logic b);
        if (!b)
            return r;
        return (r == 2'd2) ? 2'd0 : r + 2'd1;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            residue_q   <= 2'd0;
            words_q     <= 8'd0;
            x_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_div3_q  <= 1'b0;
            out_words_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            residue_q   <= residue_d;
            words_q     <= words_d;
            x_q         <= x_d;
            bit_valid_q <= bit_valid_d;
            out_valid_q <= out_valid_d;
            out_div3_q  <= out_div3_d;
            out_words_q <= out_words_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = last_q ? DONE : IDLE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. Bit 0 is presented on x in the cycle right after
    // acceptance, so the shift register keeps only the remaining WIDTH-1
    // bits and cnt counts those. The residue absorbs each bit on the same
    // edge that puts it on x, so it is complete by the final SHIFT cycle,
    // where the verdict is latched.
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        residue_d   = residue_q;
        words_d     = words_q;
        x_d         = 1'b0;
        bit_valid_d = 1'b0;
        out_valid_d = out_valid_q;
        out_div3_d  = out_div3_q;
        out_words_d = out_words_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d     = in_data >> 1;
                    cnt_d       = CW'(WIDTH - 1);
                    last_d      = in_last;
                    words_d     = (words_q == 8'd255) ? 8'd255 : words_q + 8'd1;
                    x_d         = in_data[0];
                    bit_valid_d = 1'b1;
                    residue_d   = bump(residue_q, in_data[0]);
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    x_d         = shreg_q[0];
                    bit_valid_d = 1'b1;
                    shreg_d     = shreg_q >> 1;
                    cnt_d       = cnt_q - CW'(1);
                    residue_d   = bump(residue_q, shreg_q[0]);
                end else if (last_q) begin
                    out_valid_d = 1'b1;
                    out_div3_d  = (residue_q == 2'd0);
                    out_words_d = words_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    residue_d   = 2'd0;
                    words_d     = 8'd0;
                end
            end
            default: ;
        endcase
    end

    // Outputs: in_ready is a pure state decode, the rest come from flops.
    always_comb begin
        in_ready  = (state_q == IDLE);
        x         = x_q;
        bit_valid = bit_valid_q;
        out_valid = out_valid_q;
        out_div3  = out_div3_q;
        out_words = out_words_q;
    end

endmodule

// File: tb/tb_ones_mod3_sequencer.sv
// Testbench for ones_mod3_sequencer. Drives directed and random frames and
// compares the serial stream and per-frame verdicts against a model that
// simply counts the ones of every word in the frame.

module tb_ones_mod3_sequencer;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         inValid;
   logic         inReady;
   logic [W-1:0] inData;
   logic         inLast;
   logic         x;
   logic         bitValid;
   logic         outValid;
   logic         outReady;
   logic         outDiv3;
   logic [7:0]   outWords;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: total ones and words of the current frame.
   int frameOnes = 0;
   int frameWords = 0;

   ones_mod3_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .in_last   (inLast),
      .x         (x),
      .bit_valid (bitValid),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_div3  (outDiv3),
      .out_words (outWords)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single point of comparison: counts and reports mismatches.
   task automatic checkOutput(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Offer one word and check its bits on x, then the cycle after the bits.
   // Called and returns just after a falling edge.
   task automatic applyStimulus(input logic [W-1:0] d, input bit last);
      int n = 0;
      inValid = 1'b1;
      inData  = d;
      inLast  = last;
      while (!inReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) begin
         checkOutput("ready_timeout", 0, 1);
         inValid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inLast  = 1'b0;
      inData  = W'($urandom);
      frameOnes  += $countones(d);
      frameWords += 1;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         checkOutput("bit_valid", int'(bitValid), 1);
         checkOutput("x", int'(x), int'(d[i]));
         checkOutput("in_ready_busy", int'(inReady), 0);
      end
      @(negedge clk);
      checkOutput("bit_valid_end", int'(bitValid), 0);
      if (last) begin
         checkOutput("out_valid_rise", int'(outValid), 1);
      end else begin
         checkOutput("in_ready_back", int'(inReady), 1);
         checkOutput("out_valid_mid", int'(outValid), 0);
      end
   endtask

   // Check the held verdict, stall the consumer while pulsing in_valid,
   // then take the verdict and clear the model.
   task automatic takeVerdict(input int stall);
      int expDiv3;
      int expWords;
      expDiv3  = (frameOnes % 3 == 0) ? 1 : 0;
      expWords = (frameWords > 255) ? 255 : frameWords;
      checkOutput("out_valid", int'(outValid), 1);
      checkOutput("out_div3", int'(outDiv3), expDiv3);
      checkOutput("out_words", int'(outWords), expWords);
      for (int k = 0; k < stall; k++) begin
         inValid = 1'b1;
         inData  = W'($urandom);
         inLast  = 1'($urandom);
         @(negedge clk);
         checkOutput("hold_valid", int'(outValid), 1);
         checkOutput("hold_div3", int'(outDiv3), expDiv3);
         checkOutput("hold_words", int'(outWords), expWords);
         checkOutput("hold_in_ready", int'(inReady), 0);
         checkOutput("hold_bit_valid", int'(bitValid), 0);
      end
      inValid  = 1'b0;
      inLast   = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      @(negedge clk);
      checkOutput("out_valid_drop", int'(outValid), 0);
      checkOutput("in_ready_after", int'(inReady), 1);
      frameOnes  = 0;
      frameWords = 0;
   endtask

   initial begin
      int nWords;
      reset    = 1'b1;
      inValid  = 1'b0;
      inData   = '0;
      inLast   = 1'b0;
      outReady = 1'b0;

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", int'(outValid), 0);
      checkOutput("rst_bit_valid", int'(bitValid), 0);
      checkOutput("rst_x", int'(x), 0);
      checkOutput("rst_out_div3", int'(outDiv3), 0);
      checkOutput("rst_out_words", int'(outWords), 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_in_ready", int'(inReady), 1);

      // Single word 0x07: three ones.
      applyStimulus(8'h07, 1'b1);
      takeVerdict(0);

      // Two words with two ones total, then a frame with three.
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h01, 1'b1);
      takeVerdict(0);
      applyStimulus(8'h03, 1'b0);
      applyStimulus(8'h01, 1'b1);
      takeVerdict(0);

      // Zero ones reports divisible.
      applyStimulus(8'h00, 1'b1);
      takeVerdict(0);

      // Word count saturation.
      for (int i = 0; i < 256; i++)
         applyStimulus(8'h00, (i == 255));
      takeVerdict(0);

      // Backpressure with in_valid pulsing.
      applyStimulus(8'hA5, 1'b1);
      takeVerdict(5);

      // Asynchronous reset in the middle of a shifting last word.
      inValid = 1'b1;
      inData  = 8'hFF;
      inLast  = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inLast  = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", int'(outValid), 0);
      checkOutput("mid_rst_bit_valid", int'(bitValid), 0);
      checkOutput("mid_rst_x", int'(x), 0);
      @(negedge clk);
      reset = 1'b0;
      frameOnes  = 0;
      frameWords = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("no_verdict", int'(outValid), 0);
      end
      applyStimulus(8'h07, 1'b1);
      takeVerdict(0);

      // Random frames with idle gaps and consumer stalls.
      for (int f = 0; f < 25; f++) begin
         nWords = $urandom_range(1, 5);
         for (int w = 0; w < nWords; w++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(W'($urandom), (w == nWords - 1));
         end
         takeVerdict($urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
